// File: rtl/ascon_round_seq.sv
// ascon_round_seq -- sequencer around an external, combinational Ascon round.
//
// The block holds the 320-bit Ascon state as five 64-bit lanes and the round
// index. On each RUN cycle it loads the one-round result that the downstream
// datapath returns. It performs no arithmetic on the state itself.
//
// Ports
//   clk_i, rst_n_i        clock; synchronous active-low reset
//   start_i, rounds_i     permutation request (6, 8 or 12 rounds; any other
//                         value means 12), accepted when start_i && ready_o
//   x0_i..x4_i            input state, sampled when the request is accepted
//   ready_o, busy_o       high in IDLE / high in RUN
//   round_cnt_o           round index (0..11) for the round datapath
//   px0_o..px4_o          current state, fed to the round datapath
//   px0_i..px4_i          one-round result returned by the round datapath
//   valid_o, x0_o..x4_o   result and its valid flag, held in DONE
//   out_ready_i           consumer acknowledge; DONE -> IDLE
//
// Optional feature, enabled by the macro ASCON_ROUND_SEQ_ABORT_EN:
//   abort_i               in RUN or DONE, clears the state and counter and
//                         returns to IDLE without a valid pulse

// One 64-bit state lane. Clear has priority over load, and load has
// priority over the round update.
module ascon_round_seq_lane #(
  parameter int VEC_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             upd_i,
  input  logic [VEC_W-1:0] ld_val_i,
  input  logic [VEC_W-1:0] upd_val_i,
  output logic [VEC_W-1:0] q_o
);
  logic [VEC_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)      q_d = '0;
    else if (ld_i)  q_d = ld_val_i;
    else if (upd_i) q_d = upd_val_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module ascon_round_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
`ifdef ASCON_ROUND_SEQ_ABORT_EN
  input  logic        abort_i,
`endif
  input  logic        start_i,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic [3:0]  round_cnt_o,
  output logic [63:0] px0_o,
  output logic [63:0] px1_o,
  output logic [63:0] px2_o,
  output logic [63:0] px3_o,
  output logic [63:0] px4_o,
  input  logic [63:0] px0_i,
  input  logic [63:0] px1_i,
  input  logic [63:0] px2_i,
  input  logic [63:0] px3_i,
  input  logic [63:0] px4_i,
  output logic        valid_o,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  input  logic        out_ready_i
);
  localparam int NUM_LANES = 5;
  localparam int VEC_W     = 64;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       ready_q, busy_q, valid_q;

  logic [NUM_LANES-1:0][VEC_W-1:0] xin, pin, st;
  logic accept, abort_w;

  assign xin = {x4_i, x3_i, x2_i, x1_i, x0_i};
  assign pin = {px4_i, px3_i, px2_i, px1_i, px0_i};

  assign accept = (state_q == S_IDLE) && start_i;

`ifdef ASCON_ROUND_SEQ_ABORT_EN
  // Abort only matters once a request has been taken; in IDLE it is a no-op
  // so a simultaneous start still goes through.
  assign abort_w = abort_i && (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ascon_round_seq_lane #(.VEC_W(VEC_W)) u_lane (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clr_i     (abort_w),
      .ld_i      (accept),
      .upd_i     (state_q == S_RUN),
      .ld_val_i  (xin[l]),
      .upd_val_i (pin[l]),
      .q_o       (st[l])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || abort_w) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          // Start index is 12 - R so the last round is always index 11.
          unique case (rounds_i)
            4'd6:    cnt_q <= 4'd6;
            4'd8:    cnt_q <= 4'd4;
            default: cnt_q <= 4'd0;
          endcase
          state_q <= S_RUN;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        S_RUN: begin
          if (cnt_q == 4'd11) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: if (out_ready_i) begin
          // Go to IDLE only; a start in this cycle is deliberately not seen.
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign round_cnt_o = cnt_q;

  assign px0_o = st[0];
  assign px1_o = st[1];
  assign px2_o = st[2];
  assign px3_o = st[3];
  assign px4_o = st[4];
  assign x0_o  = st[0];
  assign x1_o  = st[1];
  assign x2_o  = st[2];
  assign x3_o  = st[3];
  assign x4_o  = st[4];
endmodule

// File: tb/tb_ascon_round_seq.sv
module tb_ascon_round_seq;
  typedef logic [4:0][63:0] st_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  rounds_i = 4'd12;
  logic [63:0] x0_i = '0, x1_i = '0, x2_i = '0, x3_i = '0, x4_i = '0;
  logic        out_ready_i = 1'b0;
`ifdef ASCON_ROUND_SEQ_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  logic        ready_o, busy_o, valid_o;
  logic [3:0]  round_cnt_o;
  logic [63:0] px0_o, px1_o, px2_o, px3_o, px4_o;
  logic [63:0] px0_i, px1_i, px2_i, px3_i, px4_i;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  ascon_round_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
`ifdef ASCON_ROUND_SEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .rounds_i(rounds_i),
    .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
    .ready_o(ready_o), .busy_o(busy_o), .round_cnt_o(round_cnt_o),
    .px0_o(px0_o), .px1_o(px1_o), .px2_o(px2_o), .px3_o(px3_o), .px4_o(px4_o),
    .px0_i(px0_i), .px1_i(px1_i), .px2_i(px2_i), .px3_i(px3_i), .px4_i(px4_i),
    .valid_o(valid_o),
    .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
    .out_ready_i(out_ready_i)
  );

  // Reference Ascon round (constant add, 5-bit S-box, linear diffusion).
  function automatic logic [63:0] ror(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic st_t rnd(st_t s, logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    logic [3:0] hi;
    hi = 4'hf - r;
    a0 = s[0]; a1 = s[1]; a2 = s[2]; a3 = s[3]; a4 = s[4];
    a2 = a2 ^ {56'h0, hi, r};
    a0 = a0 ^ a4; a4 = a4 ^ a3; a2 = a2 ^ a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 = a0 ^ t1; a1 = a1 ^ t2; a2 = a2 ^ t3; a3 = a3 ^ t4; a4 = a4 ^ t0;
    a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
    a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
    a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
    return {a4, a3, a2, a1, a0};
  endfunction

  function automatic st_t perm(st_t s, int r);
    st_t t = s;
    for (int k = 12 - r; k < 12; k++) t = rnd(t, 4'(k));
    return t;
  endfunction

  function automatic st_t mkst(logic [63:0] seed);
    st_t t;
    for (int j = 0; j < 5; j++) t[j] = (seed << (8 * j)) | (seed >> (64 - 8 * j)) ^ 64'(j * 64'h0101_0101);
    if (seed == 64'h0) t = '0;
    return t;
  endfunction

  // Stand-in for the downstream round datapath.
  st_t pout, pin;
  assign pout = {px4_o, px3_o, px2_o, px1_o, px0_o};
  always_comb pin = rnd(pout, round_cnt_o);
  assign {px4_i, px3_i, px2_i, px1_i, px0_i} = pin;

  st_t xout;
  assign xout = {x4_o, x3_o, x2_o, x1_o, x0_o};

  task automatic chk(string name, logic [319:0] act, logic [319:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_x(st_t s);
    {x4_i, x3_i, x2_i, x1_i, x0_i} = s;
  endtask

  typedef struct {
    logic [3:0]  rounds;
    logic [63:0] seed;
    int          cnt0;  // expected first round index
    int          lat;   // expected edges from accept to valid (= effective R)
  } vec_t;

  vec_t vecs[7];

  // Accept a request, scramble the inputs, track the round index until valid,
  // then compare the result against the reference permutation and release.
  task automatic run_vec(vec_t v, string tag);
    st_t s;
    int  edges;
    bit  seq_bad;
    s = mkst(v.seed);
    chk({tag, ".ready"}, 320'(ready_o), 320'(1));
    drive_x(s);
    rounds_i = v.rounds;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    rounds_i = 4'd6;
    drive_x(mkst(64'(unsigned'($urandom())) | 64'h1));
    chk({tag, ".busy"}, {318'(0), busy_o, ready_o}, 320'(2));
    edges = 0;
    seq_bad = 0;
    while (!valid_o && edges < 20) begin
      if (int'(round_cnt_o) != v.cnt0 + edges) seq_bad = 1;
      step();
      edges++;
    end
    chk({tag, ".cntseq"}, 320'(seq_bad), 320'(0));
    chk({tag, ".latency"}, 320'(edges), 320'(v.lat));
    chk({tag, ".result"}, xout, perm(s, v.lat));
    chk({tag, ".px_eq_x"}, pout, xout);
    chk({tag, ".done_cnt"}, 320'(round_cnt_o), 320'(11));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk({tag, ".release"}, {317'(0), ready_o, busy_o, valid_o}, 320'(4));
  endtask

  initial begin
    st_t hold, s;
    bit  bad;
    int  n;

    vecs[0] = '{4'd12, 64'h0,                  0, 12};
    vecs[1] = '{4'd6,  64'h0123_4567_89ab_cdef, 6, 6};
    vecs[2] = '{4'd8,  64'hfedc_ba98_7654_3210, 4, 8};
    vecs[3] = '{4'd5,  64'hdead_beef_cafe_f00d, 0, 12};
    vecs[4] = '{4'd0,  64'h8000_0000_0000_0001, 0, 12};
    vecs[5] = '{4'd15, 64'h5555_aaaa_3333_cccc, 0, 12};
    vecs[6] = '{4'd12, 64'h0f1e_2d3c_4b5a_6978, 0, 12};

    // Reset state
    step(); step();
    rst_n_i = 1'b1;
    chk("rst.flags", {316'(0), ready_o, busy_o, valid_o, 1'b0}, 320'(8));
    chk("rst.cnt", 320'(round_cnt_o), 320'(0));
    chk("rst.state", xout, 320'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Result held in DONE while the consumer stalls and inputs churn
    s = mkst(64'h1357_9bdf_2468_ace0);
    drive_x(s);
    rounds_i = 4'd8;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin step(); n++; end
    chk("hold.latency", 320'(n), 320'(8));
    hold = xout;
    chk("hold.result", hold, perm(s, 8));
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      start_i = c[0];
      drive_x(mkst(64'(unsigned'($urandom())) | 64'h1));
      step();
      if (xout !== hold || ready_o !== 1'b0 || valid_o !== 1'b1 || busy_o !== 1'b0) bad = 1;
    end
    chk("hold.stable", 320'(bad), 320'(0));
    start_i = 1'b1;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("hold.to_idle", {317'(0), ready_o, busy_o, valid_o}, 320'(4));
    start_i = 1'b0;
    step();
    chk("hold.no_accept", {318'(0), ready_o, busy_o}, 320'(2));

    // Reset in the middle of a run
    drive_x(mkst(64'h2222_4444_8888_1111));
    rounds_i = 4'd12;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (round_cnt_o != 4'd5 && n < 20) begin step(); n++; end
    chk("mrst.reach5", 320'(round_cnt_o), 320'(5));
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    chk("mrst.flags", {317'(0), ready_o, busy_o, valid_o}, 320'(4));
    chk("mrst.cnt", 320'(round_cnt_o), 320'(0));
    chk("mrst.state", xout, 320'(0));
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (valid_o !== 1'b0) bad = 1;
    end
    chk("mrst.no_valid", 320'(bad), 320'(0));
    run_vec(vecs[6], "mrst.rerun");

`ifdef ASCON_ROUND_SEQ_ABORT_EN
    // Abort in RUN
    drive_x(mkst(64'h7777_0000_9999_3333));
    rounds_i = 4'd12;
    start_i  = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (round_cnt_o != 4'd3 && n < 20) begin step(); n++; end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort.flags", {317'(0), ready_o, busy_o, valid_o}, 320'(4));
    chk("abort.cnt", 320'(round_cnt_o), 320'(0));
    chk("abort.state", xout, 320'(0));
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (valid_o !== 1'b0) bad = 1;
    end
    chk("abort.no_valid", 320'(bad), 320'(0));
    // Abort in IDLE does not block a start
    s = mkst(64'h0bad_f00d_1234_5678);
    drive_x(s);
    rounds_i = 4'd12;
    start_i  = 1'b1;
    abort_i  = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort.idle_accept", {318'(0), busy_o, ready_o}, 320'(2));
    n = 1;
    while (!valid_o && n < 20) begin step(); n++; end
    chk("abort.idle_latency", 320'(n), 320'(12));
    chk("abort.idle_result", xout, perm(s, 12));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/ascon_round_seq.md
ASCON_ROUND_SEQ -- requirements
Module: ascon_round_seq

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n_i  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: start_i  in  1  request to permute the input state; accepted when start_i && ready_o.
REQ-004 SHALL have: rounds_i  in  4  rounds to run, sampled at accept; 6, 8 or 12.
REQ-005 SHALL have: x0_i..x4_i  in  64 each  input state words, sampled at accept.
REQ-006 SHALL have: ready_o  out  1  high only in IDLE.
REQ-007 SHALL have: busy_o  out  1  high in RUN.
REQ-008 SHALL have: round_cnt_o  out  4  round index driven to the downstream round datapath.
REQ-009 SHALL have: px0_o..px4_o  out  64 each  registered state words fed to the round datapath.
REQ-010 SHALL have: px0_i..px4_i  in  64 each  combinational one-round result returned by the round datapath.
REQ-011 SHALL have: valid_o  out  1  result valid, high in DONE.
REQ-012 SHALL have: x0_o..x4_o  out  64 each  result words, equal to the state registers.
REQ-013 SHALL have: out_ready_i  in  1  consumer acknowledges the result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE, on start_i=1: state regs <= x*_i; round_cnt_o <= 12 - R; next state RUN. R is rounds_i, except that any value other than 6 or 8 SHALL be treated as 12.
REQ-016 RUN, each edge: state regs <= px*_i. If round_cnt_o==11, next state is DONE and round_cnt_o holds; otherwise round_cnt_o increments by 1.
REQ-017 px*_o SHALL always equal the state regs; round_cnt_o SHALL be the registered counter and never exceed 11.
REQ-018 Latency: valid_o SHALL rise exactly R rising edges after the accepting edge, for a total of R datapath evaluations.
REQ-019 DONE: x*_o and valid_o SHALL be held stable until out_ready_i=1; on that edge the block goes to IDLE and valid_o drops.
REQ-020 start_i SHALL be ignored outside IDLE, including in the DONE cycle where out_ready_i=1; no back-to-back accept is allowed from DONE.
REQ-021 x*_i and rounds_i changes after accept SHALL have no effect on the run in progress.
REQ-022 The block SHALL perform no arithmetic on state data; the 4-bit counter arithmetic SHALL never wrap.

Reset
REQ-023 On a rising edge with rst_n_i=0: FSM <= IDLE, state regs <= 0, round_cnt_o <= 0, valid_o=0, busy_o=0, ready_o=1 from the first cycle after reset.
REQ-024 Reset SHALL take priority over all other inputs, including mid-RUN and in DONE; a partial result SHALL be discarded and never flagged valid.

Configuration
REQ-025 Macro ASCON_ROUND_SEQ_ABORT_EN defined: the block SHALL add port abort_i (in, 1).
REQ-026 With ASCON_ROUND_SEQ_ABORT_EN, abort_i=1 in RUN or DONE: next state IDLE, state regs <= 0, round_cnt_o <= 0, no valid_o pulse. Abort SHALL take priority over round advance and out_ready_i; it SHALL be ignored in IDLE, where start_i is still accepted.
REQ-027 Macro undefined: no abort_i port, and behaviour SHALL be exactly as in REQ-014..REQ-024.

Verification
REQ-028 Test: rounds_i=12, zero state, start -> round_cnt_o sequence 0..11, valid_o after 12 edges, x*_o matches the golden Ascon-p12 model.
REQ-029 Test: rounds_i=6 and rounds_i=8 -> round_cnt_o starts at 6 and 4 respectively, valid_o after 6 and 8 edges, results match the p6/p8 model.
REQ-030 Test: rounds_i=5 -> behaves as 12 (starts at 0, valid after 12 edges).
REQ-031 Test: hold out_ready_i=0 for 10 cycles in DONE while toggling start_i and x*_i -> x*_o stable, ready_o=0, no new accept; then out_ready_i=1 -> IDLE on the next edge.
REQ-032 Test: rst_n_i=0 at RUN round 5 -> next cycle IDLE, all regs 0, ready_o=1; a following start runs a full permutation correctly.
REQ-033 Test (ABORT_EN build): abort_i at round 3 -> IDLE, valid_o never asserted; abort_i in IDLE together with start -> start accepted.
